// File: rtl/hex_digit_scanner.sv
// Four-digit common-anode seven-segment scanner with per-frame shadow word and inter-digit blanking.
// Optional LEADING_ZERO_BLANK_EN: digits above the most significant nonzero nibble stay dark.
module hex_digit_scanner #(
    parameter int PRESCALE     = 50000,
    parameter int BLANK_CYCLES = 500
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] value,
    input  logic [3:0]  dp_mask,
    input  logic        enable,
    output logic [3:0]  an_n,
    output logic [6:0]  seg_n,
    output logic        dp_n,
    output logic        frame_start
);

    localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);
    localparam logic [CW-1:0] SLOT_LAST  = CW'(PRESCALE - 1);

    typedef enum logic [1:0] {
        OFF   = 2'd0,
        BLANK = 2'd1,
        DRIVE = 2'd2
    } state_t;

    state_t        r_state;
    logic [CW-1:0] r_cnt;
    logic [1:0]    r_dig;
    logic [15:0]   r_shadow;
    logic [3:0]    r_an_n;
    logic [6:0]    r_seg_n;
    logic          r_dp_n;
    logic          r_frame_start;

    function automatic logic [6:0] f_decode(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'h0: seg = 7'h40;
            4'h1: seg = 7'h79;
            4'h2: seg = 7'h24;
            4'h3: seg = 7'h30;
            4'h4: seg = 7'h19;
            4'h5: seg = 7'h12;
            4'h6: seg = 7'h02;
            4'h7: seg = 7'h78;
            4'h8: seg = 7'h00;
            4'h9: seg = 7'h10;
            4'hA: seg = 7'h08;
            4'hB: seg = 7'h03;
            4'hC: seg = 7'h46;
            4'hD: seg = 7'h21;
            4'hE: seg = 7'h06;
            default: seg = 7'h0E;
        endcase
        return seg;
    endfunction

    logic [3:0] w_nibble;
    logic       w_show;
    logic [3:0] w_drive_an;
    logic [6:0] w_drive_seg;
    logic       w_drive_dp;

    assign w_nibble = r_shadow[{r_dig, 2'b00} +: 4];

`ifdef LEADING_ZERO_BLANK_EN
    logic [1:0] r_top_dig;

    function automatic logic [1:0] f_msd(input logic [15:0] v);
        logic [1:0] idx;
        if (v[15:12] != 4'h0)     idx = 2'd3;
        else if (v[11:8] != 4'h0) idx = 2'd2;
        else if (v[7:4] != 4'h0)  idx = 2'd1;
        else                      idx = 2'd0;
        return idx;
    endfunction

    assign w_show = (r_dig <= r_top_dig);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_top_dig <= 2'd0;
        end else if (enable) begin
            // Track the shadow loads exactly: frame entry from OFF and wrap after digit 3.
            if (r_state == OFF)
                r_top_dig <= f_msd(value);
            else if (r_state == DRIVE && r_cnt == SLOT_LAST && r_dig == 2'd3)
                r_top_dig <= f_msd(value);
        end
    end
`else
    assign w_show = 1'b1;
`endif

    assign w_drive_an  = w_show ? ~(4'b0001 << r_dig) : 4'hF;
    assign w_drive_seg = w_show ? f_decode(w_nibble) : 7'h7F;
    assign w_drive_dp  = w_show ? ~dp_mask[r_dig] : 1'b1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= OFF;
            r_cnt         <= '0;
            r_dig         <= 2'd0;
            r_shadow      <= 16'h0000;
            r_an_n        <= 4'hF;
            r_seg_n       <= 7'h7F;
            r_dp_n        <= 1'b1;
            r_frame_start <= 1'b0;
        end else if (!enable) begin
            r_state       <= OFF;
            r_cnt         <= '0;
            r_dig         <= 2'd0;
            r_an_n        <= 4'hF;
            r_seg_n       <= 7'h7F;
            r_dp_n        <= 1'b1;
            r_frame_start <= 1'b0;
        end else begin
            r_frame_start <= 1'b0;
            case (r_state)
                OFF: begin
                    r_state       <= BLANK;
                    r_cnt         <= '0;
                    r_dig         <= 2'd0;
                    r_shadow      <= value;
                    r_frame_start <= 1'b1;
                    r_an_n        <= 4'hF;
                    r_seg_n       <= 7'h7F;
                    r_dp_n        <= 1'b1;
                end
                BLANK: begin
                    r_cnt <= r_cnt + CW'(1);
                    if (r_cnt == BLANK_LAST) begin
                        r_state <= DRIVE;
                        r_an_n  <= w_drive_an;
                        r_seg_n <= w_drive_seg;
                        r_dp_n  <= w_drive_dp;
                    end else begin
                        r_an_n  <= 4'hF;
                        r_seg_n <= 7'h7F;
                        r_dp_n  <= 1'b1;
                    end
                end
                DRIVE: begin
                    if (r_cnt == SLOT_LAST) begin
                        r_state <= BLANK;
                        r_cnt   <= '0;
                        r_dig   <= r_dig + 2'd1;
                        r_an_n  <= 4'hF;
                        r_seg_n <= 7'h7F;
                        r_dp_n  <= 1'b1;
                        if (r_dig == 2'd3) begin
                            r_shadow      <= value;
                            r_frame_start <= 1'b1;
                        end
                    end else begin
                        r_cnt   <= r_cnt + CW'(1);
                        r_an_n  <= w_drive_an;
                        r_seg_n <= w_drive_seg;
                        r_dp_n  <= w_drive_dp;
                    end
                end
                default: begin
                    r_state <= OFF;
                    r_cnt   <= '0;
                    r_dig   <= 2'd0;
                    r_an_n  <= 4'hF;
                    r_seg_n <= 7'h7F;
                    r_dp_n  <= 1'b1;
                end
            endcase
        end
    end

    assign an_n        = r_an_n;
    assign seg_n       = r_seg_n;
    assign dp_n        = r_dp_n;
    assign frame_start = r_frame_start;

endmodule

// File: tb/tb_hex_digit_scanner.sv
// Directed bench for hex_digit_scanner with PRESCALE=8, BLANK_CYCLES=2 (honours LEADING_ZERO_BLANK_EN).
module tb_hex_digit_scanner;

    logic        clk;
    logic        reset;
    logic [15:0] value;
    logic [3:0]  dp_mask;
    logic        enable;
    logic [3:0]  an_n;
    logic [6:0]  seg_n;
    logic        dp_n;
    logic        frame_start;

    int vectors;
    int miscompares;

    logic [6:0] seg_tab [16];

    hex_digit_scanner #(.PRESCALE(8), .BLANK_CYCLES(2)) dut (
        .clk         (clk),
        .reset       (reset),
        .value       (value),
        .dp_mask     (dp_mask),
        .enable      (enable),
        .an_n        (an_n),
        .seg_n       (seg_n),
        .dp_n        (dp_n),
        .frame_start (frame_start)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk_dark(input string tag);
        chk({tag, " an"}, {4'h0, an_n}, 8'h0F);
        chk({tag, " seg"}, {1'b0, seg_n}, 8'h7F);
        chk({tag, " dp"}, {7'h0, dp_n}, 8'h01);
        chk({tag, " fs"}, {7'h0, frame_start}, 8'h00);
    endtask

    // k counts cycles since the enable edge; 32 cycles per frame, 8 per slot, first 2 of a slot dark.
    task automatic chk_cycle(input int k, input logic [15:0] v, input logic [3:0] dpm);
        int         p;
        int         slot;
        int         off;
        bit         shown;
        logic [3:0] e_an;
        logic [6:0] e_seg;
        logic       e_dp;
        logic [3:0] nib;
        p     = k % 32;
        slot  = p / 8;
        off   = p % 8;
        shown = 1'b1;
`ifdef LEADING_ZERO_BLANK_EN
        begin
            int top;
            if (v[15:12] != 4'h0)     top = 3;
            else if (v[11:8] != 4'h0) top = 2;
            else if (v[7:4] != 4'h0)  top = 1;
            else                      top = 0;
            if (slot > top) shown = 1'b0;
        end
`endif
        e_an  = 4'hF;
        e_seg = 7'h7F;
        e_dp  = 1'b1;
        if (off >= 2 && shown) begin
            e_an[slot] = 1'b0;
            nib        = v[slot*4 +: 4];
            e_seg      = seg_tab[nib];
            e_dp       = ~dpm[slot];
        end
        chk($sformatf("an k=%0d", k), {4'h0, an_n}, {4'h0, e_an});
        chk($sformatf("dp k=%0d", k), {7'h0, dp_n}, {7'h0, e_dp});
        chk($sformatf("fs k=%0d", k), {7'h0, frame_start}, {7'h0, (p == 0)});
        if (off < 2 || shown)
            chk($sformatf("seg k=%0d", k), {1'b0, seg_n}, {1'b0, e_seg});
    endtask

    initial begin
        seg_tab = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
        vectors     = 0;
        miscompares = 0;
        reset   = 1'b1;
        enable  = 1'b0;
        value   = 16'h0000;
        dp_mask = 4'h0;

        repeat (2) @(negedge clk);
        chk_dark("reset");
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_dark($sformatf("idle%0d", i));
        end

        // Frames 0-1 show 0x1234; value switches to 0xABCD mid digit-2 DRIVE of frame 1.
        value  = 16'h1234;
        enable = 1'b1;
        for (int k = 0; k < 108; k++) begin
            tick();
            chk_cycle(k, (k < 64) ? 16'h1234 : 16'hABCD, (k < 64) ? 4'h0 : 4'b0100);
            if (k == 51) value = 16'hABCD;
            if (k == 63) dp_mask = 4'b0100;
        end
        chk("d digit0 frame2", {1'b0, seg_tab[13]}, 8'h21);

        // Drop enable during digit 1 DRIVE.
        enable = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_dark($sformatf("drop%0d", i));
        end

        value   = 16'h0070;
        dp_mask = 4'h0;
        enable  = 1'b1;
        for (int k = 0; k < 36; k++) begin
            tick();
            chk_cycle(k, 16'h0070, 4'h0);
        end
        chk("digit0 driven before reset", {4'h0, an_n}, 8'h0E);

        // Asynchronous reset mid-slot.
        @(posedge clk);
        #2 reset = 1'b1;
        #1 chk_dark("async reset");
        enable = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        tick();
        chk_dark("post reset");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
